// File: rtl/fw_wishbone_sram_initiator_if.sv
// Command/response and Wishbone bus bundle for fw_wishbone_sram_initiator.
// master: the initiator side. slave: the command source / bus target side.
interface fw_wishbone_sram_initiator_if #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 32
);
   localparam int SEL_WIDTH = DAT_WIDTH / 8;

   // command channel
   logic                 req_valid;
   logic                 req_ready;
   logic [ADR_WIDTH-1:0] req_adr;
   logic                 req_we;
   logic [DAT_WIDTH-1:0] req_dat;
   logic [SEL_WIDTH-1:0] req_sel;

   // response channel
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DAT_WIDTH-1:0] rsp_dat;
   logic                 rsp_err;

   // Wishbone classic bus
   logic [ADR_WIDTH-1:0] wb_adr;
   logic [DAT_WIDTH-1:0] wb_dat_w;
   logic [DAT_WIDTH-1:0] wb_dat_r;
   logic                 wb_cyc;
   logic                 wb_stb;
   logic                 wb_we;
   logic [SEL_WIDTH-1:0] wb_sel;
   logic                 wb_ack;
   logic                 wb_err;

   modport master (
      input  req_valid, req_adr, req_we, req_dat, req_sel,
      input  rsp_ready,
      input  wb_dat_r, wb_ack, wb_err,
      output req_ready,
      output rsp_valid, rsp_dat, rsp_err,
      output wb_adr, wb_dat_w, wb_cyc, wb_stb, wb_we, wb_sel
   );

   modport slave (
      output req_valid, req_adr, req_we, req_dat, req_sel,
      output rsp_ready,
      output wb_dat_r, wb_ack, wb_err,
      input  req_ready,
      input  rsp_valid, rsp_dat, rsp_err,
      input  wb_adr, wb_dat_w, wb_cyc, wb_stb, wb_we, wb_sel
   );
endinterface

// File: rtl/fw_wishbone_sram_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator.
// One accepted command becomes one Wishbone cycle; the result (read data or
// error) is returned on the response channel. All outputs are registered.
// Optional feature: define FW_WB_INITIATOR_TIMEOUT_EN to terminate a cycle
// with an error after TIMEOUT_CYCLES clocks without ack/err.
module fw_wishbone_sram_initiator #(
   parameter int ADR_WIDTH      = 32,
   parameter int DAT_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                          clock,
   input logic                          reset_n,
   fw_wishbone_sram_initiator_if.master bus
);
   localparam int SEL_WIDTH = DAT_WIDTH / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, CYCLE = 2'd1, RESP = 2'd2} state_t;

   state_t               state_q, state_d;
   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 cyc_q, cyc_d;        // drives both cyc and stb
   logic                 wb_we_q, wb_we_d;
   logic [ADR_WIDTH-1:0] wb_adr_q, wb_adr_d;
   logic [DAT_WIDTH-1:0] wb_dat_w_q, wb_dat_w_d;
   logic [SEL_WIDTH-1:0] wb_sel_q, wb_sel_d;
   logic                 tmo_hit;             // terminal count reached this clock

`ifdef FW_WB_INITIATOR_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;

   assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
   assign tmo_hit     = (state_q == CYCLE) && (tmo_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   // Counter sits at zero outside a cycle and counts every clock spent waiting.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == CYCLE) tmo_cnt_d = tmo_cnt_inc;
   end

   // Timeout counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) tmo_cnt_q <= '0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state and next-output logic; err beats ack, ack beats timeout.
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      cyc_d       = cyc_q;
      wb_we_d     = wb_we_q;
      wb_adr_d    = wb_adr_q;
      wb_dat_w_d  = wb_dat_w_q;
      wb_sel_d    = wb_sel_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               wb_adr_d    = bus.req_adr;
               wb_we_d     = bus.req_we;
               wb_dat_w_d  = bus.req_we ? bus.req_dat : '0;
               wb_sel_d    = bus.req_sel;
               cyc_d       = 1'b1;
               req_ready_d = 1'b0;
               state_d     = CYCLE;
            end
         end
         CYCLE: begin
            if (bus.wb_err || (!bus.wb_ack && tmo_hit)) begin
               cyc_d       = 1'b0;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = '0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (bus.wb_ack) begin
               cyc_d       = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = wb_we_q ? '0 : bus.wb_dat_r;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            // ready comes back only one clock after the handshake
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset drops cyc/stb and any pending response.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         cyc_q       <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_adr_q    <= '0;
         wb_dat_w_q  <= '0;
         wb_sel_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         cyc_q       <= cyc_d;
         wb_we_q     <= wb_we_d;
         wb_adr_q    <= wb_adr_d;
         wb_dat_w_q  <= wb_dat_w_d;
         wb_sel_q    <= wb_sel_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.wb_cyc    = cyc_q;
   assign bus.wb_stb    = cyc_q;
   assign bus.wb_we     = wb_we_q;
   assign bus.wb_adr    = wb_adr_q;
   assign bus.wb_dat_w  = wb_dat_w_q;
   assign bus.wb_sel    = wb_sel_q;
endmodule

// File: tb/tb_fw_wishbone_sram_initiator.sv
// Self-checking bench for fw_wishbone_sram_initiator.
// Expected outputs come from a per-transaction timeline: accept at cycle 0,
// bus cycle over cycles 1..N+1 (or 1..TMO on timeout), response until the
// rsp handshake, ready again the clock after.
module tb_fw_wishbone_sram_initiator;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fw_wishbone_sram_initiator_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

   fw_wishbone_sram_initiator #(
      .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clk), .reset_n(rst_n), .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // model expectations for the current cycle
   logic          chk_en = 1'b0;
   logic          e_req_ready, e_cyc, e_we, e_rsp_valid, e_rsp_err;
   logic [AW-1:0] e_adr;
   logic [DW-1:0] e_dat_w, e_rsp_dat;
   logic [3:0]    e_sel;

   // per-transaction measurements taken from the DUT
   int            rel, m_cyc_hi, m_rsp_hi, m_first_rsp;
   logic [DW-1:0] m_rsp_dat;
   logic          m_rsp_err;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   // compare DUT against model every cycle, away from the rising edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", bus.req_ready, e_req_ready);
         chk("wb_cyc", bus.wb_cyc, e_cyc);
         chk("wb_stb", bus.wb_stb, e_cyc);
         if (e_cyc) begin
            chk("wb_adr", bus.wb_adr, e_adr);
            chk("wb_we", bus.wb_we, e_we);
            chk("wb_dat_w", bus.wb_dat_w, e_dat_w);
            chk("wb_sel", bus.wb_sel, e_sel);
         end
         chk("rsp_valid", bus.rsp_valid, e_rsp_valid);
         if (e_rsp_valid) begin
            chk("rsp_dat", bus.rsp_dat, e_rsp_dat);
            chk("rsp_err", bus.rsp_err, e_rsp_err);
         end
         if (bus.wb_cyc === 1'b1) m_cyc_hi++;
         if (bus.rsp_valid === 1'b1) begin
            m_rsp_hi++;
            if (m_first_rsp < 0) begin
               m_first_rsp = rel;
               m_rsp_dat   = bus.rsp_dat;
               m_rsp_err   = bus.rsp_err;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_idle(input logic rr);
      e_req_ready = rr;
      e_cyc       = 1'b0;
      e_rsp_valid = 1'b0;
   endtask

   task automatic bus_noise();
      bus.wb_ack   = 1'($urandom % 2);
      bus.wb_err   = ($urandom % 4) == 0;
      bus.wb_dat_r = $urandom;
      bus.rsp_ready = 1'($urandom % 2);
   endtask

   task automatic req_noise();
      bus.req_valid = 1'($urandom % 2);
      bus.req_adr   = $urandom;
      bus.req_we    = 1'($urandom % 2);
      bus.req_dat   = $urandom;
      bus.req_sel   = 4'($urandom);
   endtask

   // mode: 0 = ack, 1 = err, 2 = ack and err together
   task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [3:0] sel, input int n_wait, input int mode,
                      input int d_rsp, input int gap, input logic [DW-1:0] rdata);
      int   last;
      logic tmo_o;
      last  = n_wait + 1;
      tmo_o = 1'b0;
`ifdef FW_WB_INITIATOR_TIMEOUT_EN
      if (n_wait + 1 > TMO) begin
         last  = TMO;
         tmo_o = 1'b1;
      end
`endif
      for (int i = 0; i < gap; i++) begin
         bus_noise();
         bus.req_valid = 1'b0;
         exp_idle(1'b1);
         rel = -1;
         step();
      end
      // accept cycle
      bus_noise();
      bus.req_valid = 1'b1;
      bus.req_adr   = adr;
      bus.req_we    = we;
      bus.req_dat   = dat;
      bus.req_sel   = sel;
      exp_idle(1'b1);
      rel = 0; m_cyc_hi = 0; m_rsp_hi = 0; m_first_rsp = -1;
      step();
      // bus cycle
      e_adr   = adr;
      e_we    = we;
      e_dat_w = we ? dat : '0;
      e_sel   = sel;
      for (int c = 1; c <= last; c++) begin
         req_noise();
         bus.rsp_ready = 1'($urandom % 2);
         bus.wb_ack    = 1'b0;
         bus.wb_err    = 1'b0;
         bus.wb_dat_r  = $urandom;
         if (c == n_wait + 1) begin
            bus.wb_ack   = (mode != 1);
            bus.wb_err   = (mode != 0);
            bus.wb_dat_r = rdata;
         end
         e_req_ready = 1'b0; e_cyc = 1'b1; e_rsp_valid = 1'b0;
         rel = c;
         step();
      end
      // response phase
      e_rsp_err = tmo_o || (mode != 0);
      e_rsp_dat = (e_rsp_err || we) ? '0 : rdata;
      for (int c = 0; c <= d_rsp; c++) begin
         req_noise();
         bus_noise();
         bus.rsp_ready = (c == d_rsp);
         e_req_ready = 1'b0; e_cyc = 1'b0; e_rsp_valid = 1'b1;
         rel = last + 1 + c;
         step();
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_adr = '0; bus.req_we = 1'b0; bus.req_dat = '0;
      bus.req_sel = '0; bus.rsp_ready = 1'b0; bus.wb_dat_r = '0; bus.wb_ack = 1'b0;
      bus.wb_err = 1'b0;
      rel = -1; m_cyc_hi = 0; m_rsp_hi = 0; m_first_rsp = -1; m_rsp_dat = '0; m_rsp_err = 1'b0;
      exp_idle(1'b0);
      e_adr = '0; e_we = 1'b0; e_dat_w = '0; e_sel = '0; e_rsp_dat = '0; e_rsp_err = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      chk("rst_wb_cyc", bus.wb_cyc, 1'b0);
      chk("rst_wb_stb", bus.wb_stb, 1'b0);
      chk("rst_wb_we", bus.wb_we, 1'b0);
      chk("rst_wb_adr", bus.wb_adr, 32'h0);
      chk("rst_wb_dat_w", bus.wb_dat_w, 32'h0);
      chk("rst_wb_sel", bus.wb_sel, 4'h0);
      #1 rst_n = 1'b1;
      step();
      chk("rst_ready_rise", bus.req_ready, 1'b1);
      chk_en = 1'b1;

      // zero-wait write
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 32'h0);
      chk("wr_cyc_cycles", m_cyc_hi, 1);
      chk("wr_rsp_cycle", m_first_rsp, 2);
      chk("wr_rsp_dat", m_rsp_dat, 32'h0);
      chk("wr_rsp_err", m_rsp_err, 1'b0);

      // read with 3 wait states
      txn(1'b0, 32'h10, 32'h0, 4'hF, 3, 0, 0, 0, 32'hDEADBEEF);
      chk("rd_cyc_cycles", m_cyc_hi, 4);
      chk("rd_rsp_cycle", m_first_rsp, 5);
      chk("rd_rsp_dat", m_rsp_dat, 32'hDEADBEEF);
      chk("rd_rsp_err", m_rsp_err, 1'b0);

      // ack and err together: err wins
      txn(1'b0, 32'h20, 32'h0, 4'h3, 1, 2, 0, 1, 32'hCAFEF00D);
      chk("ackerr_rsp_err", m_rsp_err, 1'b1);
      chk("ackerr_rsp_dat", m_rsp_dat, 32'h0);

      // response back-pressure for 5 cycles
      txn(1'b0, 32'h24, 32'h0, 4'hF, 0, 0, 5, 0, 32'h0BADF00D);
      chk("bp_rsp_cycles", m_rsp_hi, 6);
      chk("bp_rsp_dat", m_rsp_dat, 32'h0BADF00D);

      // reset pulsed during a bus cycle
      bus_noise();
      bus.req_valid = 1'b1; bus.req_adr = 32'h40; bus.req_we = 1'b0; bus.req_sel = 4'hF;
      exp_idle(1'b1);
      step();
      bus.req_valid = 1'b0; bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
      e_req_ready = 1'b0; e_cyc = 1'b1; e_rsp_valid = 1'b0;
      e_adr = 32'h40; e_we = 1'b0; e_dat_w = '0; e_sel = 4'hF;
      step();
      rst_n = 1'b0;
      bus.wb_ack = 1'b1; bus.rsp_ready = 1'b1;
      exp_idle(1'b0);
      #1;
      chk("rst_async_cyc", bus.wb_cyc, 1'b0);
      chk("rst_async_stb", bus.wb_stb, 1'b0);
      chk("rst_async_rsp_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      exp_idle(1'b1);
      chk("rst_mid_ready_rise", bus.req_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus_noise();
         step();
      end

`ifdef FW_WB_INITIATOR_TIMEOUT_EN
      txn(1'b0, 32'h50, 32'h0, 4'hF, 20, 0, 1, 0, 32'h0);
      chk("tmo_cyc_cycles", m_cyc_hi, 8);
      chk("tmo_rsp_err", m_rsp_err, 1'b1);
      chk("tmo_rsp_dat", m_rsp_dat, 32'h0);
      // ack on the terminal-count clock wins
      txn(1'b0, 32'h54, 32'h0, 4'hF, 7, 0, 0, 0, 32'h12345678);
      chk("tmo_edge_cyc_cycles", m_cyc_hi, 8);
      chk("tmo_edge_rsp_err", m_rsp_err, 1'b0);
      chk("tmo_edge_rsp_dat", m_rsp_dat, 32'h12345678);
`else
      txn(1'b0, 32'h50, 32'h0, 4'hF, 999, 0, 0, 0, 32'h12345678);
      chk("notmo_cyc_cycles", m_cyc_hi, 1000);
      chk("notmo_rsp_err", m_rsp_err, 1'b0);
      chk("notmo_rsp_dat", m_rsp_dat, 32'h12345678);
`endif

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         int mode;
         mode = (($urandom % 5) == 0) ? 1 : ((($urandom % 8) == 0) ? 2 : 0);
         txn(1'($urandom % 2), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 5)),
             mode, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
      end

      bus.req_valid = 1'b0;
      exp_idle(1'b1);
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
